// File: rtl/cmd_pkg.sv
// Shared constants and encodings for the command-line reader: character codes,
// buffer/table sizes, FSM states and command ids.
package cmd_pkg;
  localparam int MAX_LEN  = 16;
  localparam int NUM_CMDS = 4;

  localparam logic [7:0] CR  = 8'h0D;
  localparam logic [7:0] LF  = 8'h0A;
  localparam logic [7:0] BS  = 8'h08;
  localparam logic [7:0] DEL = 8'h7F;

  typedef enum logic [1:0] {
    RECEIVE = 2'd0,
    MATCH   = 2'd1,
    REPORT  = 2'd2
  } state_e;

  localparam logic [1:0] CMD_HELP    = 2'd0;
  localparam logic [1:0] CMD_LED_ON  = 2'd1;
  localparam logic [1:0] CMD_LED_OFF = 2'd2;
  localparam logic [1:0] CMD_STATUS  = 2'd3;
endpackage

// File: rtl/cmd_reader_if.sv
// Byte-in / echo-out / result bundle between uart_rx, the reader and the control FSM.
interface cmd_reader_if;
  import cmd_pkg::*;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] echo_data;
  logic       echo_enable;
  logic       cmd_valid;
  logic [1:0] cmd_id;
  logic       cmd_error;
  logic       busy;
  logic [4:0] line_len;

  modport master (
    output rx_data, rx_valid,
    input  echo_data, echo_enable, cmd_valid, cmd_id, cmd_error, busy, line_len
  );
  modport slave (
    input  rx_data, rx_valid,
    output echo_data, echo_enable, cmd_valid, cmd_id, cmd_error, busy, line_len
  );
endinterface

// File: rtl/cmd_rom.sv
// Fixed command table; character 0 of each entry sits in text[7:0].
module cmd_rom
  import cmd_pkg::*;
(
  input  logic [1:0]           id,
  output logic [MAX_LEN*8-1:0] text,
  output logic [4:0]           length
);
  // String literals are right-aligned with the first character highest; flip them.
  function automatic logic [MAX_LEN*8-1:0] pack(input logic [63:0] s, input int n);
    logic [MAX_LEN*8-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < n) r[i*8 +: 8] = s[(n-1-i)*8 +: 8];
    end
    return r;
  endfunction

  always_comb begin
    text   = '0;
    length = 5'd0;
    case (id)
      CMD_HELP:    begin text = pack("help", 4);    length = 5'd4; end
      CMD_LED_ON:  begin text = pack("led on", 6);  length = 5'd6; end
      CMD_LED_OFF: begin text = pack("led off", 7); length = 5'd7; end
      CMD_STATUS:  begin text = pack("status", 6);  length = 5'd6; end
      default:     begin text = '0;                 length = 5'd0; end
    endcase
  end
endmodule

// File: rtl/cmd_reader.sv
// Line assembler with editing/echo that resolves a completed line against cmd_rom,
// one table character per cycle, and pulses either a command id or an error.
module cmd_reader
  import cmd_pkg::*;
(
  input logic         clk,
  input logic         rst,
  cmd_reader_if.slave bus
);
  localparam logic [4:0] MAX_LEN_W = 5'(MAX_LEN);

  state_e               state_q, state_d;
  logic [7:0]           line_buf_q [MAX_LEN];
  logic [4:0]           len_q, len_d;
  logic                 ovf_q, ovf_d;
  logic [1:0]           cmd_idx_q, cmd_idx_d;
  logic [3:0]           char_idx_q, char_idx_d;
  logic [7:0]           echo_data_q, echo_data_d;
  logic                 echo_en_q, echo_en_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic [1:0]           cmd_id_q, cmd_id_d;
  logic                 cmd_error_q, cmd_error_d;
  logic                 busy_q, busy_d;
  logic                 wr_en;
  logic [7:0]           folded;
  logic                 printable;
  logic                 advance;
  logic [MAX_LEN*8-1:0] rom_text;
  logic [4:0]           rom_len;

  cmd_rom u_rom (.id(cmd_idx_q), .text(rom_text), .length(rom_len));

  assign printable = (bus.rx_data >= 8'h20) && (bus.rx_data <= 8'h7E);
  assign folded    = ((bus.rx_data >= "A") && (bus.rx_data <= "Z")) ? (bus.rx_data | 8'h20)
                                                                    : bus.rx_data;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    ovf_d       = ovf_q;
    cmd_idx_d   = cmd_idx_q;
    char_idx_d  = char_idx_q;
    echo_data_d = echo_data_q;
    echo_en_d   = 1'b0;
    cmd_valid_d = 1'b0;
    cmd_id_d    = cmd_id_q;
    cmd_error_d = 1'b0;
    wr_en       = 1'b0;
    advance     = 1'b0;
    case (state_q)
      RECEIVE: begin
        if (bus.rx_valid) begin
          if (printable) begin
            if (len_q < MAX_LEN_W) begin
              wr_en       = 1'b1;
              len_d       = len_q + 5'd1;
              echo_en_d   = 1'b1;
              echo_data_d = folded;
            end else begin
              ovf_d = 1'b1;
            end
          end else if ((bus.rx_data == BS) || (bus.rx_data == DEL)) begin
            if (len_q != 5'd0) begin
              len_d       = len_q - 5'd1;
              echo_en_d   = 1'b1;
              echo_data_d = BS;
            end
          end else if (bus.rx_data == CR) begin
            if (ovf_q) begin
              state_d     = REPORT;
              cmd_error_d = 1'b1;
            end else if (len_q != 5'd0) begin
              state_d    = MATCH;
              cmd_idx_d  = 2'd0;
              char_idx_d = 4'd0;
            end
          end
        end
      end
      MATCH: begin
        // Length check first: a wrong-length entry is rejected without touching the buffer.
        if (rom_len != len_q) begin
          advance = 1'b1;
        end else if (line_buf_q[char_idx_q] != rom_text[{char_idx_q, 3'b000} +: 8]) begin
          advance = 1'b1;
        end else if ({1'b0, char_idx_q} == rom_len - 5'd1) begin
          state_d     = REPORT;
          cmd_valid_d = 1'b1;
          cmd_id_d    = cmd_idx_q;
        end else begin
          char_idx_d = char_idx_q + 4'd1;
        end
        if (advance) begin
          char_idx_d = 4'd0;
          if (cmd_idx_q == 2'(NUM_CMDS - 1)) begin
            state_d     = REPORT;
            cmd_error_d = 1'b1;
          end else begin
            cmd_idx_d = cmd_idx_q + 2'd1;
          end
        end
      end
      REPORT: begin
        state_d = RECEIVE;
        len_d   = 5'd0;
        ovf_d   = 1'b0;
      end
      default: state_d = RECEIVE;
    endcase
    busy_d = (state_d != RECEIVE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RECEIVE;
      len_q       <= 5'd0;
      ovf_q       <= 1'b0;
      cmd_idx_q   <= 2'd0;
      char_idx_q  <= 4'd0;
      echo_data_q <= 8'd0;
      echo_en_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_id_q    <= 2'd0;
      cmd_error_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      cmd_idx_q   <= cmd_idx_d;
      char_idx_q  <= char_idx_d;
      echo_data_q <= echo_data_d;
      echo_en_q   <= echo_en_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_id_q    <= cmd_id_d;
      cmd_error_q <= cmd_error_d;
      busy_q      <= busy_d;
    end
  end

  // Line storage is data only; line_len decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) line_buf_q[len_q[3:0]] <= folded;
  end

  assign bus.echo_data   = echo_data_q;
  assign bus.echo_enable = echo_en_q;
  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_id      = cmd_id_q;
  assign bus.cmd_error   = cmd_error_q;
  assign bus.busy        = busy_q;
  assign bus.line_len    = len_q;
endmodule

// File: tb/tb_cmd_reader.sv
// Bench for cmd_reader: transaction-level reference model (line queue + table lookup
// with latency arithmetic) compared against the DUT every cycle, plus directed literals.
module tb_cmd_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  cmd_reader_if bus();

  cmd_reader dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  string cmd_tab [4] = '{"help", "led on", "led off", "status"};

  int n_pass = 0, n_total = 0;
  int cyc = 0;

  // Reference model state
  logic [7:0] mline [$];
  bit         movf;
  int         busy_left;
  bit         res_hit;
  int         res_id;
  bit         exp_echo_en, exp_valid, exp_err, exp_busy;
  logic [7:0] exp_echo_data;
  logic [1:0] exp_id;
  int         exp_len;

  // Observations for directed checks
  logic [7:0] echo_log [$];
  int         pulse_cyc, pulse_id, n_valid, n_err;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void str2q(input string s, output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endfunction

  // Rejected entry costs 1 cycle on length mismatch, else first-mismatch index + 1;
  // the hit costs its length.
  function automatic void resolve(input logic [7:0] ln[$], output int lat,
                                  output bit hit, output int id);
    lat = 0; hit = 0; id = 0;
    for (int k = 0; k < 4; k++) begin
      string t = cmd_tab[k];
      if (t.len() != ln.size()) lat += 1;
      else begin
        int m = -1;
        for (int j = 0; j < t.len(); j++) if (m < 0 && ln[j] != t[j]) m = j;
        if (m < 0) begin lat += t.len(); hit = 1; id = k; return; end
        lat += m + 1;
      end
    end
  endfunction

  function automatic void model_reset();
    mline = {}; movf = 0; busy_left = 0; res_hit = 0; res_id = 0;
    exp_echo_en = 0; exp_valid = 0; exp_err = 0; exp_busy = 0;
    exp_echo_data = 0; exp_id = 0; exp_len = 0;
  endfunction

  function automatic void pulse();
    if (res_hit) begin exp_valid = 1; exp_id = 2'(res_id); end
    else exp_err = 1;
  endfunction

  function automatic void model_update(input bit v, input logic [7:0] d);
    logic [7:0] f;
    int lat;
    exp_echo_en = 0; exp_valid = 0; exp_err = 0;
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 1) pulse();
      else if (busy_left == 0) begin mline = {}; movf = 0; exp_busy = 0; end
    end else if (v) begin
      f = (d >= "A" && d <= "Z") ? d + 8'd32 : d;
      if (d >= 8'h20 && d <= 8'h7E) begin
        if (mline.size() < 16) begin
          mline.push_back(f); exp_echo_en = 1; exp_echo_data = f;
        end else movf = 1;
      end else if (d == 8'h08 || d == 8'h7F) begin
        if (mline.size() > 0) begin
          void'(mline.pop_back()); exp_echo_en = 1; exp_echo_data = 8'h08;
        end
      end else if (d == 8'h0D && (movf || mline.size() > 0)) begin
        if (movf) begin lat = 0; res_hit = 0; end
        else resolve(mline, lat, res_hit, res_id);
        busy_left = lat + 1;
        exp_busy = 1;
        if (busy_left == 1) pulse();
      end
    end
    exp_len = mline.size();
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check("echo_enable", bus.echo_enable, exp_echo_en);
      if (exp_echo_en) check("echo_data", bus.echo_data, exp_echo_data);
      check("cmd_valid", bus.cmd_valid, exp_valid);
      check("cmd_error", bus.cmd_error, exp_err);
      check("cmd_id", bus.cmd_id, exp_id);
      check("busy", bus.busy, exp_busy);
      check("line_len", bus.line_len, exp_len);
      if (bus.echo_enable) echo_log.push_back(bus.echo_data);
      if (bus.cmd_valid) begin pulse_cyc = cyc; pulse_id = bus.cmd_id; n_valid++; end
      if (bus.cmd_error) begin pulse_cyc = cyc; n_err++; end
    end
  end

  task automatic step(input bit v, input logic [7:0] d);
    bus.rx_valid = v;
    bus.rx_data  = d;
    @(posedge clk);
    #1;
    cyc++;
    model_update(v, d);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s, input int max_gap);
    for (int i = 0; i < s.len(); i++) begin
      step(1'b1, s[i]);
      repeat ($urandom_range(max_gap, 0)) step(1'b0, 8'h00);
    end
  endtask

  task automatic wait_idle(input bit inject);
    for (int i = 0; i < 200 && busy_left > 0; i++) begin
      if (inject && ($urandom_range(3, 0) == 0)) step(1'b1, 8'($urandom_range(8'h7E, 8'h20)));
      else step(1'b0, 8'h00);
    end
    check("idle_timeout", busy_left, 0);
    step(1'b0, 8'h00);
  endtask

  task automatic expect_echo(input string name, input logic [7:0] exp[$]);
    check({name, "_echo_count"}, echo_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < echo_log.size(); i++)
      check({name, "_echo_byte"}, echo_log[i], exp[i]);
  endtask

  task automatic mid_reset();
    #1;
    rst = 1'b1;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_line_len", bus.line_len, 0);
    check("rst_cmd_valid", bus.cmd_valid, 0);
    check("rst_cmd_error", bus.cmd_error, 0);
    check("rst_echo_enable", bus.echo_enable, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] eq[$];
    int lat, id, cr_cyc, errs0, vals0;
    bit hit;

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_echo_enable", bus.echo_enable, 0);
    check("reset_echo_data", bus.echo_data, 0);
    check("reset_cmd_valid", bus.cmd_valid, 0);
    check("reset_cmd_error", bus.cmd_error, 0);
    check("reset_cmd_id", bus.cmd_id, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_line_len", bus.line_len, 0);
    rst = 1'b0;

    // Pin the model's table/latency arithmetic with hand-computed values.
    str2q("help", q);    resolve(q, lat, hit, id);
    check("model_help_lat", lat, 4); check("model_help_id", id, 0); check("model_help_hit", hit, 1);
    str2q("led off", q); resolve(q, lat, hit, id);
    check("model_ledoff_lat", lat, 9); check("model_ledoff_id", id, 2);
    str2q("status", q);  resolve(q, lat, hit, id);
    check("model_status_lat", lat, 9); check("model_status_id", id, 3);
    str2q("foo", q);     resolve(q, lat, hit, id);
    check("model_foo_lat", lat, 4); check("model_foo_hit", hit, 0);

    // "help" with exact result latency
    echo_log = {}; errs0 = n_err; pulse_cyc = -1;
    send_str("help", 0);
    cr_cyc = cyc;
    step(1'b1, 8'h0D);
    wait_idle(1'b0);
    eq = '{8'h68, 8'h65, 8'h6C, 8'h70};
    expect_echo("help", eq);
    check("help_latency", pulse_cyc - cr_cyc, 5);
    check("help_id", pulse_id, 0);
    check("help_no_error", n_err, errs0);

    // Uppercase folding
    echo_log = {};
    send_str("LED OFF", 1);
    step(1'b1, 8'h0D);
    wait_idle(1'b0);
    str2q("led off", eq);
    expect_echo("ledoff", eq);
    check("ledoff_id", pulse_id, 2);

    // Same length as "led on" but not a command
    errs0 = n_err;
    send_str("led of", 0);
    step(1'b1, 8'h0D);
    wait_idle(1'b0);
    check("ledof_error", n_err, errs0 + 1);

    // Backspace on empty line, then in-line edit
    echo_log = {};
    step(1'b1, 8'h08);
    step(1'b0, 8'h00);
    check("bs_empty_no_echo", echo_log.size(), 0);
    send_str("helq", 0);
    step(1'b1, 8'h08);
    send_str("p", 0);
    step(1'b1, 8'h0D);
    wait_idle(1'b0);
    eq = '{8'h68, 8'h65, 8'h6C, 8'h71, 8'h08, 8'h70};
    expect_echo("edit", eq);
    check("edit_id", pulse_id, 0);

    // Overflow: 17 printable bytes
    echo_log = {}; errs0 = n_err; pulse_cyc = -1;
    send_str("abcdefghijklmnopq", 0);
    check("ovf_echo_count", echo_log.size(), 16);
    check("ovf_line_len", bus.line_len, 16);
    cr_cyc = cyc;
    step(1'b1, 8'h0D);
    wait_idle(1'b0);
    check("ovf_error_latency", pulse_cyc - cr_cyc, 1);
    check("ovf_error_count", n_err, errs0 + 1);
    check("ovf_line_len_after", bus.line_len, 0);

    // Unknown command and bare CR
    errs0 = n_err; vals0 = n_valid;
    send_str("foo", 0);
    step(1'b1, 8'h0D);
    wait_idle(1'b0);
    check("foo_error_count", n_err, errs0 + 1);
    step(1'b1, 8'h0D);
    repeat (3) step(1'b0, 8'h00);
    check("bare_cr_no_error", n_err, errs0 + 1);
    check("bare_cr_no_valid", n_valid, vals0);

    // Reset in the middle of matching
    vals0 = n_valid; errs0 = n_err;
    send_str("help", 0);
    step(1'b1, 8'h0D);
    step(1'b0, 8'h00);
    mid_reset();
    repeat (6) step(1'b0, 8'h00);
    check("rst_no_pulse", n_valid + n_err, vals0 + errs0);
    send_str("status", 0);
    step(1'b1, 8'h0D);
    wait_idle(1'b0);
    check("after_rst_id", pulse_id, 3);

    // Randomized lines
    for (int n = 0; n < 40; n++) begin
      string s;
      int kind = $urandom_range(3, 0);
      s = "";
      case (kind)
        0: begin
          s = cmd_tab[$urandom_range(3, 0)];
          for (int i = 0; i < s.len(); i++)
            if (s[i] >= "a" && s[i] <= "z" && $urandom_range(1, 0) == 1) s[i] = s[i] - 8'd32;
        end
        1: for (int i = 0; i < $urandom_range(8, 1); i++)
             s = {s, string'(8'($urandom_range(8'h7E, 8'h20)))};
        2: for (int i = 0; i < $urandom_range(20, 17); i++)
             s = {s, string'(8'($urandom_range(8'h7A, 8'h61)))};
        default: begin
          s = cmd_tab[$urandom_range(3, 0)];
          s = {s.substr(0, 1), "x", string'(8'h7F), s.substr(2, s.len() - 1)};
        end
      endcase
      send_str(s, 2);
      if ($urandom_range(3, 0) == 0) step(1'b1, 8'h0A);
      step(1'b1, 8'h0D);
      wait_idle(1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/cmd_reader.md
# cmd_reader

Receive-side counterpart of the string printer: assembles bytes from the UART receiver into a command line, with line editing and echo, and resolves the line against a fixed command table. Sits between `uart_rx` and the top-level control FSM; echo bytes go toward the TX mux. It emits one result pulse per non-empty line: either a matched command id or an error.

## Interface
- `MAX_LEN`, 16: line buffer depth in characters.
- `NUM_CMDS`, 4: entries in the command table.
- `clk` input 1: system clock.
- `rst` input 1: reset. One clock; reset is asynchronous and active-high.
- `rx_data` input 8: received byte, valid only when `rx_valid` is high.
- `rx_valid` input 1: one-cycle strobe from `uart_rx`.
- `echo_data` output 8: byte to echo.
- `echo_enable` output 1: one-cycle echo strobe.
- `cmd_valid` output 1: one-cycle pulse; `cmd_id` holds the matched command.
- `cmd_id` output 2: matched command index; holds its value until the next result.
- `cmd_error` output 1: one-cycle pulse for an unknown command or an overflowed line.
- `busy` output 1: high in MATCH and REPORT; `rx_valid` bytes are dropped while it is high.
- `line_len` output 5: current buffer fill, 0..MAX_LEN.

## Operation
- States:
  - RECEIVE: reset state.
  - MATCH.
  - REPORT: lasts exactly 1 cycle, then RECEIVE.
- Reset values: all outputs 0, `line_len` 0, overflow flag clear, state RECEIVE.
- Reset mid-line or mid-match: the line is discarded and no pulse is emitted.
- Byte handling in RECEIVE, on `rx_valid`:
  - 'A'-'Z': folded to lowercase before storage and echo.
  - 0x20-0x7E, `line_len` < MAX_LEN: store at index `line_len`, increment, echo the stored byte.
  - Printable, `line_len` == MAX_LEN: not stored, not echoed, set the sticky overflow flag.
  - 0x08 or 0x7F, `line_len` > 0: decrement `line_len`, echo 0x08.
  - 0x08 or 0x7F, `line_len` == 0: ignored, no echo.
  - Backspace does not clear overflow.
  - 0x0D with `line_len` 0 and no overflow: ignored, no pulse.
  - 0x0D with overflow: go to REPORT with error.
  - 0x0D otherwise: go to MATCH with `cmd_idx`=0, `char_idx`=0.
  - 0x0A and all other bytes: ignored.
- Command table, held in `cmd_rom`:
  - 0 "help"
  - 1 "led on"
  - 2 "led off"
  - 3 "status"
- MATCH, one action per cycle:
  - ROM length ≠ `line_len`: advance `cmd_idx`.
  - Otherwise compare `buf[char_idx]` with the ROM character.
  - Character mismatch: advance `cmd_idx` and reset `char_idx`.
  - Character match at `char_idx` == length−1: go to REPORT with a hit.
  - Character match otherwise: increment `char_idx`.
  - Advancing past `cmd_idx` == NUM_CMDS−1: go to REPORT with error.
- REPORT:
  - `cmd_valid` (with `cmd_id`) or `cmd_error` is high for this single cycle.
  - On exit, `line_len` and overflow clear.
- Priority: `rst` over everything. Simultaneous events do not otherwise occur, since only one byte arrives per strobe.

## Timing
- Echo: `echo_enable` and `echo_data` are registered, asserted in cycle T+1 for a byte strobed at T.
- Buffer write: visible through `line_len` at T+1.
- Overflowed CR at T: `cmd_error` at T+1.
- MATCH latency: each rejected command costs 1 cycle if its length differs, else first-mismatch index + 1. The hit costs its length in cycles. REPORT follows the final compare.
  - "help", CR at T: compares T+1..T+4, `cmd_valid` at T+5.
- `busy` is registered: high from T+1 through the REPORT cycle. A byte arriving in the REPORT cycle is dropped.
- Worst-case line is never slower than NUM_CMDS×MAX_LEN+1 cycles. This is far below one UART byte time, so at line rate no bytes are lost.

## Structure
- Shared package `cmd_pkg`:
  - character constants CR, LF, BS, DEL;
  - `MAX_LEN`, `NUM_CMDS`;
  - state encoding;
  - command id constants `CMD_HELP`, `CMD_LED_ON`, `CMD_LED_OFF`, `CMD_STATUS`.
- Sub-module `cmd_rom`: combinational.
  - Input `id`[1:0].
  - Outputs `text`[MAX_LEN*8-1:0], character 0 in bits [7:0].
  - Output `length`[4:0].
- Buffer: plain register array, no RAM inference required.

## Test plan
- Bytes "h","e","l","p",0x0D → echo 68 65 6C 70; `cmd_valid`=1 with `cmd_id`=0 exactly 5 cycles after the CR strobe; `cmd_error` never high.
- "LED OFF",0x0D → echo shows lowercase "led off"; `cmd_valid` with `cmd_id`=2. A variant starting with "led o" must reject id 1 on the length check.
- "helq",BS,"p",0x0D → echo 68 65 6C 71 08 70; `cmd_id`=0. A BS on an empty line produces no echo.
- 17 printable bytes then 0x0D → 16 echoes, `line_len` saturates at 16, `cmd_error` at CR+1, `line_len` 0 after REPORT.
- "foo",0x0D → `cmd_error` once after all 4 commands rejected. A bare 0x0D produces no pulse.
- `rst` asserted while in MATCH → state RECEIVE, `busy`, `line_len` and all pulses 0 immediately; the next "status",0x0D → `cmd_id`=3.
